// File: rtl/dmem_store_responder.sv
// Data-memory responder: posted-write store buffer drained into a word RAM,
// plus a result mailbox. Define STORE_FWD_EN to forward pending stores to loads.
module dmem_store_responder #(
  parameter int          DEPTH        = 4,
  parameter int          WORDS        = 64,
  parameter logic [31:0] MAILBOX_ADDR = 32'd100,
  parameter logic [31:0] EXPECT       = 32'd25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        Pass,
  output logic        Err
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   data;
    logic          mbox;
  } entry_t;

  entry_t        buffer [DEPTH];
  logic [31:0]   ram    [WORDS];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   mailbox;

  logic [IW-1:0] wordIdx;
  logic          aligned, isMbox, full;
  logic          match, loadHazard, push, drain;
  logic [31:0]   fwdData;
  entry_t        headEntry;

  assign wordIdx   = DataAdr[IW+1:2];
  assign aligned   = (DataAdr[1:0] == 2'b00);
  assign isMbox    = (DataAdr == MAILBOX_ADDR);
  assign full      = (count == CW'(DEPTH));
  assign headEntry = buffer[head];

  // Scan oldest to youngest so the last hit is the youngest pending store.
  always_comb begin
    match   = 1'b0;
    fwdData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count &&
          buffer[head + PW'(i)].idx  == wordIdx &&
          buffer[head + PW'(i)].mbox == isMbox) begin
        match   = 1'b1;
        fwdData = buffer[head + PW'(i)].data;
      end
    end
  end

`ifdef STORE_FWD_EN
  assign loadHazard = 1'b0;
`else
  assign loadHazard = MemRead && match;
`endif

  // A misaligned store is dropped rather than held, so it never stalls.
  assign Stall = (MemWrite && aligned && full) || loadHazard;
  assign push  = MemWrite && aligned && !Stall;
  assign drain = (count != '0) && (!MemRead || loadHazard);

  // Without forwarding a hit always stalls the load, so the value is don't-care.
  always_comb begin
    ReadData = isMbox ? mailbox : ram[wordIdx];
    if (match) ReadData = fwdData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      mailbox <= '0;
      Done    <= 1'b0;
      Pass    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      if (push)  tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drain && headEntry.mbox) begin
        mailbox <= headEntry.data;
        Done    <= 1'b1;
        if (headEntry.data == EXPECT) Pass <= 1'b1;
      end
      if (MemWrite && !aligned) Err <= 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; validity comes from the reset
  // pointers and count, and a reset RAM would not map onto block memory.
  always_ff @(posedge clk) begin
    if (push) buffer[tail] <= '{idx: wordIdx, data: WriteData, mbox: isMbox};
  end

  always_ff @(posedge clk) begin
    if (drain && !headEntry.mbox) ram[headEntry.idx] <= headEntry.data;
  end

endmodule

// File: tb/tb_dmem_store_responder.sv
// Randomized and directed bench for dmem_store_responder against a queue-based
// model of the store buffer, RAM and mailbox flags.
module tb_dmem_store_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] DataAdr, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Done, Pass, Err;

  dmem_store_responder dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .Done(Done), .Pass(Pass), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          mbox;
  } ent_t;

  ent_t        q[$];
  logic [31:0] ramM [64];
  bit          known [64];
  logic [31:0] mboxM;
  bit          doneM, passM, errM;
  bit          lastStall;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit findYoungest(input int idx, input bit mb, output logic [31:0] d);
    findYoungest = 1'b0;
    d = '0;
    foreach (q[i]) begin
      if (q[i].idx == idx && q[i].mbox == mb) begin
        findYoungest = 1'b1;
        d = q[i].data;
      end
    end
  endfunction

  // Called at a falling edge; checks outputs, clocks once, updates the model.
  task automatic cycle(input bit we, input bit re, input logic [31:0] adr, input logic [31:0] wd);
    bit          al, mb, hit, haz, st, drn, psh, expKnown;
    int          idx;
    logic [31:0] fd, expRd;
    ent_t        e;
    MemWrite = we; MemRead = re; DataAdr = adr; WriteData = wd;
    #1;
    al  = (adr[1:0] == 2'b00);
    idx = int'(adr[7:2]);
    mb  = (adr == 32'd100);
    hit = findYoungest(idx, mb, fd);
`ifdef STORE_FWD_EN
    haz = 1'b0;
`else
    haz = re && hit;
`endif
    st = (we && al && q.size() == 4) || haz;
    check("stall", Stall, st);
    check("done", Done, doneM);
    check("pass", Pass, passM);
    check("err", Err, errM);
    if (re && !st) begin
      expKnown = 1'b1;
      if (hit)             expRd = fd;
      else if (mb)         expRd = mboxM;
      else if (known[idx]) expRd = ramM[idx];
      else begin expRd = '0; expKnown = 1'b0; end
      if (expKnown) check("rdata", ReadData, expRd);
    end
    drn = (q.size() > 0) && (!re || haz);
    psh = we && al && !st;
    lastStall = st;
    @(posedge clk);
    if (drn) begin
      e = q.pop_front();
      if (e.mbox) begin
        mboxM = e.data;
        doneM = 1'b1;
        if (e.data == 32'd25) passM = 1'b1;
      end else begin
        ramM[e.idx]  = e.data;
        known[e.idx] = 1'b1;
      end
    end
    if (psh) q.push_back('{idx, wd, mb});
    if (we && !al) errM = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Reset pulse between edges; called at a falling edge, returns before the next rise.
  task automatic pulseReset();
    MemWrite = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_stall", Stall, 1'b0);
    check("rst_done", Done, 1'b0);
    reset = 1'b0;
    q.delete();
    mboxM = '0; doneM = 1'b0; passM = 1'b0; errM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit we, re;
    int idx;
    logic [31:0] adr, wd;
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; DataAdr = '0; WriteData = '0;
    mboxM = '0; doneM = 1'b0; passM = 1'b0; errM = 1'b0;
    foreach (known[i]) known[i] = 1'b0;
    @(negedge clk);
    check("reset_done", Done, 1'b0);
    check("reset_pass", Pass, 1'b0);
    check("reset_err", Err, 1'b0);
    check("reset_stall", Stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Give every non-mailbox word a known value.
    for (int i = 0; i < 64; i++) if (i != 25) cycle(1'b1, 1'b0, 32'(i * 4), $urandom);
    idle(6);

    // Pass program: 96<-7 then mailbox<-25.
    pulseReset();
    cycle(1'b1, 1'b0, 32'd96, 32'd7);
    cycle(1'b1, 1'b0, 32'd100, 32'd25);
    idle(2);
    cycle(1'b0, 1'b1, 32'd96, 32'd0);
    cycle(1'b0, 1'b1, 32'd100, 32'd0);

    // Fail value then pass value; both flags sticky.
    pulseReset();
    cycle(1'b1, 1'b0, 32'd100, 32'd24);
    idle(2);
    cycle(1'b1, 1'b0, 32'd100, 32'd25);
    idle(2);
    cycle(1'b1, 1'b0, 32'd100, 32'd3);
    idle(2);

    // Continuous loads block draining; fifth store stalls until a slot frees.
    cycle(1'b0, 1'b1, 32'd0, 32'd0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 32'h10 + 32'(4 * k), 32'hA000 + 32'(k));
    check("full_stall", lastStall, 1'b1);
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 32'h20, 32'hA004);
      n++;
    end while (lastStall && n < 8);
    check("hold_bound", n, 2);
    idle(5);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 32'h10 + 32'(4 * k), 32'd0);

    // Load right behind a store to the same word.
    cycle(1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 32'h40, 32'd0);
      n++;
    end while (lastStall && n < 8);
    check("raw_bound", n < 8, 1'b1);
    idle(2);

    // Reset discards pending stores without touching RAM.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 32'h50 + 32'(4 * k), 32'hBAD0 + 32'(k));
    pulseReset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 32'h50 + 32'(4 * k), 32'd0);
    idle(2);

    // Misaligned stores: empty buffer and full buffer.
    cycle(1'b1, 1'b0, 32'h42, 32'h1234);
    idle(1);
    pulseReset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 32'h60 + 32'(4 * k), 32'hC000 + 32'(k));
    cycle(1'b1, 1'b1, 32'h62, 32'h5555);
    cycle(1'b1, 1'b1, 32'h70, 32'h6666);
    idle(5);

    // Randomized traffic.
    pulseReset();
    for (int t = 0; t < 400; t++) begin
      we  = ($urandom_range(0, 1) == 1);
      re  = ($urandom_range(0, 2) == 0);
      idx = $urandom_range(0, 15) + 16 * $urandom_range(0, 3);
      adr = 32'(idx * 4);
      if ($urandom_range(0, 15) == 0) adr = adr + 32'($urandom_range(1, 3));
      wd  = (adr == 32'd100 && $urandom_range(0, 1) == 1) ? 32'd25 : $urandom;
      cycle(we, re, adr, wd);
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
